id_ex_pipeline_reg: RTL and testbench

ID/EX pipeline register of the 5-stage RISC-V pipeline. It captures decoded control, operands and instruction fields from the ID stage and presents them to the EX stage: ALU control decode, ALU, forwarding and branch-compare logic. It supports hazard-unit stall (hold) and flush (bubble insertion), tracks a per-slot valid bit, and keeps a saturating bubble counter for performance debug.

---
 rtl/id_ex_pipeline_reg.sv | 133 +++++++++++++
 tb/tb_id_ex_pipeline_reg.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: holds one decoded instruction slot for the EX stage,
// with hazard stall/flush, valid tracking and a saturating bubble counter.
module id_ex_pipeline_reg #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [6:0]      id_funct7,
  input  logic [2:0]      id_funct3,
  input  logic [1:0]      id_alu_op,
  input  logic            id_alu_src,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_reg_write,
  input  logic            id_mem_to_reg,
  input  logic            id_branch,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [6:0]      ex_funct7,
  output logic [2:0]      ex_funct3,
  output logic [1:0]      ex_alu_op,
  output logic            ex_alu_src,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_mem_to_reg,
  output logic            ex_branch,
  output logic [CNT_W-1:0] bubble_count
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [1:0]      alu_op;
    logic            alu_src;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem_to_reg;
    logic            branch;
  } slot_t;

  slot_t            slot_q, slot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_bubble;

  // An invalid ID slot is squashed exactly like a flush so no control leaks into EX.
  assign load_bubble = flush || (!stall && !id_valid);

  always_comb begin
    slot_d = slot_q;
    cnt_d  = cnt_q;
    if (load_bubble) begin
      slot_d = '0;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!stall) begin
      slot_d.valid      = 1'b1;
      slot_d.pc         = id_pc;
      slot_d.rs1_data   = id_rs1_data;
      slot_d.rs2_data   = id_rs2_data;
      slot_d.imm        = id_imm;
      slot_d.rs1        = id_rs1;
      slot_d.rs2        = id_rs2;
      slot_d.rd         = id_rd;
      slot_d.funct7     = id_funct7;
      slot_d.funct3     = id_funct3;
      slot_d.alu_op     = id_alu_op;
      slot_d.alu_src    = id_alu_src;
      slot_d.mem_read   = id_mem_read;
      slot_d.mem_write  = id_mem_write;
      slot_d.reg_write  = id_reg_write;
      slot_d.mem_to_reg = id_mem_to_reg;
      slot_d.branch     = id_branch;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= '0;
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ex_valid      = slot_q.valid;
  assign ex_pc         = slot_q.pc;
  assign ex_rs1_data   = slot_q.rs1_data;
  assign ex_rs2_data   = slot_q.rs2_data;
  assign ex_imm        = slot_q.imm;
  assign ex_rs1        = slot_q.rs1;
  assign ex_rs2        = slot_q.rs2;
  assign ex_rd         = slot_q.rd;
  assign ex_funct7     = slot_q.funct7;
  assign ex_funct3     = slot_q.funct3;
  assign ex_alu_op     = slot_q.alu_op;
  assign ex_alu_src    = slot_q.alu_src;
  assign ex_mem_read   = slot_q.mem_read;
  assign ex_mem_write  = slot_q.mem_write;
  assign ex_reg_write  = slot_q.reg_write;
  assign ex_mem_to_reg = slot_q.mem_to_reg;
  assign ex_branch     = slot_q.branch;
  assign bubble_count  = cnt_q;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Directed bench for id_ex_pipeline_reg: reset, load, stall, flush, invalid slot
// and bubble-counter saturation (counter built 4 bits wide).
module tb_id_ex_pipeline_reg;
  localparam int XLEN  = 64;
  localparam int CNT_W = 4;

  logic            clk = 1'b0;
  logic            reset, stall, flush, id_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [6:0]      id_funct7;
  logic [2:0]      id_funct3;
  logic [1:0]      id_alu_op;
  logic            id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [6:0]      ex_funct7;
  logic [2:0]      ex_funct3;
  logic [1:0]      ex_alu_op;
  logic            ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch;
  logic [CNT_W-1:0] bubble_count;

  int tests = 0;
  int fails = 0;
  int exp_cnt;

  always #5 clk = ~clk;

  id_ex_pipeline_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct7(id_funct7),
    .id_funct3(id_funct3), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct7(ex_funct7),
    .ex_funct3(ex_funct3), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .bubble_count(bubble_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a();
    id_valid = 1'b1; id_pc = 64'h100; id_rs1_data = 64'h1111; id_rs2_data = 64'h2222;
    id_imm = 64'hFFFF_FFFF_FFFF_FFF0; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd5;
    id_funct7 = 7'b0100000; id_funct3 = 3'b000; id_alu_op = 2'b10;
    id_alu_src = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    id_reg_write = 1'b1; id_mem_to_reg = 1'b0; id_branch = 1'b0;
  endtask

  initial begin
    // Reset with everything nonzero on the ID side.
    reset = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b1;
    id_pc = 64'hDEAD_BEEF_0000_1234; id_rs1_data = 64'hA5A5; id_rs2_data = 64'h5A5A;
    id_imm = 64'h77; id_rs1 = 5'd31; id_rs2 = 5'd30; id_rd = 5'd29;
    id_funct7 = 7'h7F; id_funct3 = 3'h7; id_alu_op = 2'b11;
    id_alu_src = 1'b1; id_mem_read = 1'b1; id_mem_write = 1'b1;
    id_reg_write = 1'b1; id_mem_to_reg = 1'b1; id_branch = 1'b1;
    step();
    step();
    chk("rst_valid", ex_valid, 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_rs2_data", ex_rs2_data, 0);
    chk("rst_alu_op", ex_alu_op, 0);
    chk("rst_rd", ex_rd, 0);
    chk("rst_reg_write", ex_reg_write, 0);
    chk("rst_mem_write", ex_mem_write, 0);
    chk("rst_mem_to_reg", ex_mem_to_reg, 0);
    chk("rst_bubble", bubble_count, 0);

    reset = 1'b0;
    step();
    $display("[TB] post-reset load pc=%0h", ex_pc);
    chk("prl_valid", ex_valid, 1);
    chk("prl_pc", ex_pc, 64'hDEAD_BEEF_0000_1234);
    chk("prl_rs1_data", ex_rs1_data, 64'hA5A5);
    chk("prl_imm", ex_imm, 64'h77);
    chk("prl_alu_op", ex_alu_op, 2'b11);
    chk("prl_funct3", ex_funct3, 3'h7);
    chk("prl_alu_src", ex_alu_src, 1);
    chk("prl_mem_to_reg", ex_mem_to_reg, 1);
    chk("prl_bubble", bubble_count, 0);

    // Normal R-type load (instruction A).
    drive_a();
    step();
    $display("[TB] load A pc=%0h rd=%0d", ex_pc, ex_rd);
    chk("ld_pc", ex_pc, 64'h100);
    chk("ld_alu_op", ex_alu_op, 2'b10);
    chk("ld_funct7", ex_funct7, 7'b0100000);
    chk("ld_funct3", ex_funct3, 3'b000);
    chk("ld_rd", ex_rd, 5);
    chk("ld_rs1", ex_rs1, 1);
    chk("ld_rs2", ex_rs2, 2);
    chk("ld_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFF0);
    chk("ld_reg_write", ex_reg_write, 1);
    chk("ld_mem_read", ex_mem_read, 0);
    chk("ld_valid", ex_valid, 1);

    // Stall 3 cycles while ID presents B.
    stall = 1'b1;
    id_pc = 64'h200; id_rd = 5'd9; id_alu_op = 2'b01; id_branch = 1'b1; id_reg_write = 1'b0;
    id_funct3 = 3'b001;
    for (int i = 0; i < 3; i++) begin
      step();
      $display("[TB] stall cycle %0d pc=%0h", i, ex_pc);
      chk("stall_pc", ex_pc, 64'h100);
      chk("stall_rd", ex_rd, 5);
      chk("stall_alu_op", ex_alu_op, 2'b10);
      chk("stall_branch", ex_branch, 0);
      chk("stall_bubble", bubble_count, 0);
    end
    stall = 1'b0;
    step();
    $display("[TB] release stall pc=%0h", ex_pc);
    chk("relB_pc", ex_pc, 64'h200);
    chk("relB_rd", ex_rd, 9);
    chk("relB_alu_op", ex_alu_op, 2'b01);
    chk("relB_funct3", ex_funct3, 3'b001);
    chk("relB_branch", ex_branch, 1);
    chk("relB_reg_write", ex_reg_write, 0);

    // Flush wins over stall.
    drive_a();
    step();
    stall = 1'b1; flush = 1'b1;
    step();
    $display("[TB] flush+stall valid=%0b bubbles=%0d", ex_valid, bubble_count);
    chk("fl_valid", ex_valid, 0);
    chk("fl_reg_write", ex_reg_write, 0);
    chk("fl_rd", ex_rd, 0);
    chk("fl_alu_op", ex_alu_op, 0);
    chk("fl_pc", ex_pc, 0);
    chk("fl_funct7", ex_funct7, 0);
    chk("fl_bubble", bubble_count, 1);

    // Invalid slot with dangerous control bits set.
    stall = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_mem_write = 1'b1; id_reg_write = 1'b1; id_mem_read = 1'b1; id_branch = 1'b1;
    step();
    $display("[TB] invalid slot bubbles=%0d", bubble_count);
    chk("inv_mem_write", ex_mem_write, 0);
    chk("inv_reg_write", ex_reg_write, 0);
    chk("inv_mem_read", ex_mem_read, 0);
    chk("inv_branch", ex_branch, 0);
    chk("inv_valid", ex_valid, 0);
    chk("inv_bubble", bubble_count, 2);

    // Stall with invalid ID holds, no count.
    stall = 1'b1;
    step();
    chk("stinv_bubble", bubble_count, 2);

    // Saturation: 20 flushes from a count of 2.
    stall = 1'b0; flush = 1'b1; id_valid = 1'b1;
    exp_cnt = 2;
    for (int i = 0; i < 20; i++) begin
      step();
      if (exp_cnt < 15) exp_cnt++;
      $display("[TB] flush %0d bubbles=%0d", i, bubble_count);
      chk("sat_bubble", bubble_count, exp_cnt);
    end

    // Valid load after saturation keeps the count.
    flush = 1'b0;
    drive_a();
    step();
    chk("satld_valid", ex_valid, 1);
    chk("satld_bubble", bubble_count, 15);

    // Reset during stall+flush overrides both.
    stall = 1'b1; flush = 1'b1; reset = 1'b1;
    step();
    chk("rstov_bubble", bubble_count, 0);
    chk("rstov_valid", ex_valid, 0);
    chk("rstov_pc", ex_pc, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
